// File: rtl/simon32_64_key_expand.sv
// SIMON32/64 key schedule: accepts a 64-bit master key, expands one 16-bit
// round key per cycle into a register file, and serves registered reads.
module simon32_64_key_expand #(
  parameter int unsigned ROUNDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [63:0] key,
  output logic        key_ready,
  input  logic [4:0]  rk_rd_idx,
  output logic [15:0] rk_rd_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

  localparam logic [61:0] Z0     = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [4:0]  LAST_I = 5'(ROUNDS - 4);
  localparam logic [5:0]  NWORDS = 6'(ROUNDS);

  state_e      state_q;
  logic [4:0]  i_q;
  logic [15:0] rk_q [ROUNDS];
  logic [15:0] rd_q, rd_d;
  logic        busy_q, done_q, ready_q;

  logic [4:0]  idx1, idx3, idx4;
  logic [15:0] k_i, k_i1, k_i3, tmp, k_new;
  logic        z_bit;

  always_comb begin
    idx1  = i_q + 5'd1;
    idx3  = i_q + 5'd3;
    idx4  = i_q + 5'd4;
    k_i   = rk_q[i_q];
    k_i1  = rk_q[idx1];
    k_i3  = rk_q[idx3];
    z_bit = Z0[6'd61 - {1'b0, i_q}];
    tmp   = {k_i3[2:0], k_i3[15:3]} ^ k_i1;
    k_new = k_i ^ tmp ^ {tmp[0], tmp[15:1]} ^ 16'hFFFC ^ {15'd0, z_bit};
  end

  always_comb begin
    rd_d = '0;
    if ({1'b0, rk_rd_idx} < NWORDS) rd_d = rk_q[rk_rd_idx];
  end

  // The EXPAND cycle with i == ROUNDS-4 writes nothing; it only retires
  // into DONE, which places the done edge at ROUNDS-3 after acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      rd_q    <= '0;
      for (int unsigned j = 0; j < ROUNDS; j++) rk_q[j] <= '0;
    end else begin
      rd_q <= rd_d;
      case (state_q)
        IDLE, DONE: begin
          if (key_valid) begin
            rk_q[0] <= key[15:0];
            rk_q[1] <= key[31:16];
            rk_q[2] <= key[47:32];
            rk_q[3] <= key[63:48];
            i_q     <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            state_q <= EXPAND;
          end
        end
        EXPAND: begin
          if (i_q == LAST_I) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= DONE;
          end else begin
            rk_q[idx4] <= k_new;
            i_q        <= i_q + 5'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_ready  = ready_q;
  assign rk_rd_data = rd_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_simon32_64_key_expand.sv
// Directed/random bench for simon32_64_key_expand against a behavioural
// SIMON32/64 key-schedule and cipher model.
module tb_simon32_64_key_expand;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid, key_valid_b;
  logic [63:0] key, key_b;
  logic        key_ready, key_ready_b;
  logic [4:0]  rk_rd_idx, rk_rd_idx_b;
  logic [15:0] rk_rd_data, rk_rd_data_b;
  logic        busy, busy_b, done, done_b;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [15:0] exp_rk [32];
  logic [15:0] dut_rk [32];

  string Z = "11111010001001010110000111001101111101000100101011000011100110";

  simon32_64_key_expand #(.ROUNDS(32)) u_dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key(key),
    .key_ready(key_ready), .rk_rd_idx(rk_rd_idx), .rk_rd_data(rk_rd_data),
    .busy(busy), .done(done)
  );

  simon32_64_key_expand #(.ROUNDS(20)) u_dut20 (
    .clk(clk), .reset(reset), .key_valid(key_valid_b), .key(key_b),
    .key_ready(key_ready_b), .rk_rd_idx(rk_rd_idx_b), .rk_rd_data(rk_rd_data_b),
    .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ror(input logic [15:0] x, input int n);
    return (x >> n) | (x << (16 - n));
  endfunction

  function automatic logic [15:0] rol(input logic [15:0] x, input int n);
    return (x << n) | (x >> (16 - n));
  endfunction

  task automatic model(input logic [63:0] k);
    logic [15:0] t;
    for (int i = 0; i < 4; i++) exp_rk[i] = k[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = ror(exp_rk[i-1], 3) ^ exp_rk[i-3];
      exp_rk[i] = exp_rk[i-4] ^ t ^ ror(t, 1) ^ 16'hFFFC ^ ((Z[i-4] == "1") ? 16'd1 : 16'd0);
    end
  endtask

  function automatic logic [31:0] encrypt(input logic [31:0] pt);
    logic [15:0] x, y, t;
    x = pt[31:16];
    y = pt[15:0];
    for (int r = 0; r < 32; r++) begin
      t = x;
      x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ dut_rk[r];
      y = t;
    end
    return {x, y};
  endfunction

  task automatic rd(input logic [4:0] idx, output logic [15:0] data);
    @(negedge clk);
    rk_rd_idx = idx;
    @(negedge clk);
    data = rk_rd_data;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), dut_rk[i]);
      chk($sformatf("%s_rk%0d", tag, i), {16'd0, dut_rk[i]}, {16'd0, exp_rk[i]});
    end
  endtask

  // Accepts k, then follows the expansion edge by edge until done.
  task automatic expand(input logic [63:0] k, input string tag, input bit glitch,
                        input bit stale_chk, input logic [15:0] stale_val);
    int n;
    @(negedge clk);
    key_valid = 1'b1;
    key       = k;
    @(negedge clk);
    key_valid = 1'b0;
    chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    chk({tag, "_done_e0"}, {31'd0, done}, 32'd0);
    chk({tag, "_rdy_e0"},  {31'd0, key_ready}, 32'd0);
    n = 0;
    while (n < 40) begin
      n++;
      key_valid = (glitch && n == 5);
      if (glitch && n == 5) key = ~k;
      @(negedge clk);
      if (stale_chk && n == 1)
        chk({tag, "_nobypass"}, {16'd0, rk_rd_data}, {16'd0, stale_val});
      if (done) break;
      chk($sformatf("%s_busy_e%0d", tag, n), {31'd0, busy}, 32'd1);
      chk($sformatf("%s_rdy_e%0d", tag, n), {31'd0, key_ready}, 32'd0);
    end
    key_valid = 1'b0;
    chk({tag, "_done_edge"}, n, 29);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_rdy_at_done"}, {31'd0, key_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] d;
    logic [63:0] k;
    int n;

    reset = 1'b0;
    key_valid = 1'b0; key = '0; rk_rd_idx = '0;
    key_valid_b = 1'b0; key_b = '0; rk_rd_idx_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, key_ready}, 32'd1);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_rdata", {16'd0, rk_rd_data}, 32'd0);
    reset = 1'b1;

    // Golden vector plus an ignored key pulse mid-expansion
    model(64'h1918111009080100);
    expand(64'h1918111009080100, "gold", 1'b1, 1'b0, 16'h0);
    read_all("gold");
    chk("gold_k0", {16'd0, dut_rk[0]}, 32'h0100);
    chk("gold_k1", {16'd0, dut_rk[1]}, 32'h0908);
    chk("gold_k2", {16'd0, dut_rk[2]}, 32'h1110);
    chk("gold_k3", {16'd0, dut_rk[3]}, 32'h1918);
    chk("gold_k4", {16'd0, dut_rk[4]}, 32'h71C3);
    chk("gold_cipher", encrypt(32'h65656877), 32'hc69be9bb);

    // Restart from DONE with random keys; index 4 read across the write edge
    for (int t = 0; t < 3; t++) begin
      k = {$urandom, $urandom};
      rk_rd_idx = 5'd4;
      d = exp_rk[4];
      model(k);
      expand(k, $sformatf("rnd%0d", t), 1'b0, 1'b1, d);
      rd(5'd31, d);
      chk($sformatf("rnd%0d_idx31", t), {16'd0, d}, {16'd0, exp_rk[31]});
      read_all($sformatf("rnd%0d", t));
    end

    // Reset at step i=10
    @(negedge clk);
    key_valid = 1'b1;
    key = {$urandom, $urandom};
    @(negedge clk);
    key_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, key_ready}, 32'd1);
    chk("midrst_busy",  {31'd0, busy}, 32'd0);
    chk("midrst_done",  {31'd0, done}, 32'd0);
    chk("midrst_rdata", {16'd0, rk_rd_data}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle_busy",  {31'd0, busy}, 32'd0);
    chk("post_rst_idle_ready", {31'd0, key_ready}, 32'd1);
    rd(5'd5, d);
    chk("post_rst_idx5", {16'd0, d}, 32'd0);

    // ROUNDS=20 instance
    k = {$urandom, $urandom};
    model(k);
    @(negedge clk);
    key_valid_b = 1'b1;
    key_b = k;
    @(negedge clk);
    key_valid_b = 1'b0;
    n = 0;
    while (n < 40 && !done_b) begin
      @(negedge clk);
      n++;
    end
    chk("r20_done_edge", n, 17);
    @(negedge clk); rk_rd_idx_b = 5'd31;
    @(negedge clk); chk("r20_idx31", {16'd0, rk_rd_data_b}, 32'd0);
    rk_rd_idx_b = 5'd20;
    @(negedge clk); chk("r20_idx20", {16'd0, rk_rd_data_b}, 32'd0);
    rk_rd_idx_b = 5'd19;
    @(negedge clk); chk("r20_idx19", {16'd0, rk_rd_data_b}, {16'd0, exp_rk[19]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/simon32_64_key_expand.md
SIMON32_64_KEY_EXPAND -- requirements
Module: simon32_64_key_expand

Interface
REQ-001 SHALL have parameter ROUNDS, default 32, meaning the number of 16-bit round keys produced; legal range is 5..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port key_valid, input, 1, meaning the upstream source is presenting a key.
REQ-005 SHALL have port key, input, 64, the master key. Word mapping: k0=key[15:0], k1=key[31:16], k2=key[47:32], k3=key[63:48].
REQ-006 SHALL have port key_ready, output, 1, meaning the block can accept a key this cycle.
REQ-007 SHALL have port rk_rd_idx, input, 5, the round-key read index.
REQ-008 SHALL have port rk_rd_data, output, 16, the registered round-key read data.
REQ-009 SHALL have port busy, output, 1, meaning expansion is in progress.
REQ-010 SHALL have port done, output, 1, meaning all ROUNDS round keys are valid.

Function
REQ-011 SHALL implement FSM states IDLE, EXPAND and DONE.
REQ-012 SHALL drive key_ready=1 in IDLE and DONE, and key_ready=0 in EXPAND.
REQ-013 SHALL accept a key only on a rising edge where key_valid=1 and key_ready=1; key_valid while key_ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-014 On acceptance, SHALL load k0..k3 into round-key registers 0..3, clear step counter i to 0, clear done, set busy, and enter EXPAND, all at the same edge.
REQ-015 In EXPAND, SHALL compute one word per cycle:
- tmp = ror3(k[i+3]) ^ k[i+1]
- k[i+4] = k[i] ^ tmp ^ ror1(tmp) ^ 16'hFFFC ^ z0[i]
- rorN is a 16-bit rotate right; all arithmetic is 16-bit XOR; z0[i] occupies bit 0 only.
REQ-016 z0 SHALL be the 62-bit constant 11111010001001010110000111001101111101000100101011000011100110, with z0[0] as the leftmost bit.
REQ-017 SHALL write k[i+4] to register i+4 and increment i every EXPAND cycle.
REQ-018 After the edge that writes register ROUNDS-1, SHALL enter DONE with done=1 and busy=0. done therefore rises on the (ROUNDS-3)th rising edge after the accepting edge, which is the 29th edge for ROUNDS=32.
REQ-019 In DONE, a new accepted key SHALL restart per REQ-014; done SHALL fall at the accepting edge.
REQ-020 The read port SHALL return register[rk_rd_idx] on rk_rd_data one cycle after rk_rd_idx is sampled.
REQ-021 A read of index >= ROUNDS SHALL return 16'h0000.
REQ-022 Reads SHALL be legal in every state. During EXPAND a read returns the current register contents, which are stale or zero for words not yet written.
REQ-023 If a read and a write target the same register in the same cycle, the read SHALL return the old value (no bypass).
REQ-024 busy and done SHALL never be 1 simultaneously.

Reset
REQ-025 reset=0 SHALL asynchronously force state=IDLE, i=0, all round-key registers=0, rk_rd_data=0, busy=0, done=0 and key_ready=1.
REQ-026 Reset asserted mid-EXPAND SHALL abandon the expansion; after deassertion the block SHALL wait in IDLE for a new key.
REQ-027 No key SHALL be accepted at the first rising edge coinciding with reset deassertion unless reset is already high at that edge.

Verification
REQ-028 The bench SHALL cover each of the following scenarios:
- Apply key=64'h1918111009080100 with ROUNDS=32, then read indices 0..4 after done. Required: 0100, 0908, 1110, 1918, 71C3. The result must also decrypt/encrypt plaintext 65656877 to ciphertext c69be9bb when the round keys are fed to simon32_64.
- Count cycles from the accepting edge to done=1. Required: exactly 29; busy=1 for the 28 cycles in between; key_ready=0 throughout.
- Pulse key_valid with a different key during EXPAND. Required: the key is ignored; the final round keys match the original key's golden model.
- Assert reset at step i=10. Required: all outputs take their reset values immediately; after release, state is IDLE and reading index 5 returns 0000.
- In DONE, apply a new key. Required: done falls at the accepting edge and rises again 29 edges later with the new keys; reading index 31 returns the golden-model value.
- Read index 31 while ROUNDS=20. Required: returns 0000.
